// File: rtl/instdecode_if.sv
// Decode-stage bus: fetch/writeback inputs and decode outputs grouped for instdecode.
// The master side drives instruction, next PC and writeback; the slave side is the decoder.
interface instdecode_if;
   logic        id_en;
   logic [31:0] ir_in;
   logic [31:0] npc_in;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] a_out;
   logic [31:0] b_out;
   logic [31:0] imm_out;
   logic [31:0] irout2;
   logic [31:0] npcout2;
   logic [4:0]  rd_out;
   logic        branch_en;
   logic [31:0] branch_target;
   logic        stall;

   modport master (
      output id_en, ir_in, npc_in, wb_en, wb_addr, wb_data,
      input  a_out, b_out, imm_out, irout2, npcout2, rd_out, branch_en, branch_target, stall
   );

   modport slave (
      input  id_en, ir_in, npc_in, wb_en, wb_addr, wb_data,
      output a_out, b_out, imm_out, irout2, npcout2, rd_out, branch_en, branch_target, stall
   );
endinterface

// File: rtl/instdecode.sv
// Instruction decode stage: register file, operand/immediate decode, branch resolve, load-use stall.
// Define ID_WB_BYPASS_EN to forward same-cycle writeback data into the read and branch paths.
module instdecode #(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
   input logic        clock2,
   input logic        reset2,
   instdecode_if.slave dec_io
);

   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeqz  = 6'h04;
   localparam logic [5:0] OpBnez  = 6'h05;

   logic [31:0] rf_q [32];

   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] npc_q, npc_d;
   logic [4:0]  rd_q, rd_d;

   logic [5:0]  opcode;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] imm_dec;
   logic [4:0]  rd_dec;
   logic        uses_rs2;
   logic        ex_is_load;
   logic        stall;
   logic        taken;

   assign opcode = dec_io.ir_in[31:26];
   assign rs1    = dec_io.ir_in[25:21];
   assign rs2    = dec_io.ir_in[20:16];

   always_comb begin
      rs1_val = rf_q[rs1];
      rs2_val = rf_q[rs2];
`ifdef ID_WB_BYPASS_EN
      if (dec_io.wb_en && (dec_io.wb_addr == rs1)) rs1_val = dec_io.wb_data;
      if (dec_io.wb_en && (dec_io.wb_addr == rs2)) rs2_val = dec_io.wb_data;
`endif
      // R0 is hardwired; this also masks any bypass targeting it.
      if (rs1 == 5'd0) rs1_val = '0;
      if (rs2 == 5'd0) rs2_val = '0;
   end

   always_comb begin
      imm_dec  = {{16{dec_io.ir_in[15]}}, dec_io.ir_in[15:0]};
      rd_dec   = dec_io.ir_in[20:16];
      uses_rs2 = 1'b0;
      taken    = 1'b0;
      if ((opcode == OpJ) || (opcode == OpJal)) begin
         imm_dec = {{6{dec_io.ir_in[25]}}, dec_io.ir_in[25:0]};
      end
      if (opcode == OpRType) begin
         rd_dec   = dec_io.ir_in[15:11];
         uses_rs2 = 1'b1;
      end else if (opcode == OpJal) begin
         rd_dec = 5'd31;
         taken  = 1'b1;
      end else if (opcode == OpJ) begin
         rd_dec = 5'd0;
         taken  = 1'b1;
      end else if ((opcode == OpBeqz) || (opcode == OpBnez)) begin
         rd_dec   = 5'd0;
         uses_rs2 = 1'b1;
         taken    = (opcode == OpBeqz) ? (rs1_val == 32'd0) : (rs1_val != 32'd0);
      end else if ((opcode >= 6'h28) && (opcode <= 6'h2B)) begin
         rd_dec   = 5'd0;
         uses_rs2 = 1'b1;
      end
   end

   assign ex_is_load = (ir_q[31:26] >= 6'h20) && (ir_q[31:26] <= 6'h25);
   assign stall      = ex_is_load && (rd_q != 5'd0) &&
                       ((rd_q == rs1) || (uses_rs2 && (rd_q == rs2)));

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      imm_d = imm_q;
      ir_d  = ir_q;
      npc_d = npc_q;
      rd_d  = rd_q;
      if (dec_io.id_en) begin
         if (stall) begin
            a_d   = '0;
            b_d   = '0;
            imm_d = '0;
            ir_d  = NOP_WORD;
            rd_d  = '0;
         end else begin
            a_d   = rs1_val;
            b_d   = rs2_val;
            imm_d = imm_dec;
            ir_d  = dec_io.ir_in;
            npc_d = dec_io.npc_in;
            rd_d  = rd_dec;
         end
      end
   end

   always_ff @(posedge clock2 or negedge reset2) begin
      if (!reset2) begin
         a_q   <= '0;
         b_q   <= '0;
         imm_q <= '0;
         ir_q  <= NOP_WORD;
         npc_q <= '0;
         rd_q  <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         imm_q <= imm_d;
         ir_q  <= ir_d;
         npc_q <= npc_d;
         rd_q  <= rd_d;
      end
   end

   always_ff @(posedge clock2 or negedge reset2) begin
      if (!reset2) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= REG_INIT;
      end else if (dec_io.wb_en && (dec_io.wb_addr != 5'd0)) begin
         rf_q[dec_io.wb_addr] <= dec_io.wb_data;
      end
   end

   assign dec_io.a_out         = a_q;
   assign dec_io.b_out         = b_q;
   assign dec_io.imm_out       = imm_q;
   assign dec_io.irout2        = ir_q;
   assign dec_io.npcout2       = npc_q;
   assign dec_io.rd_out        = rd_q;
   assign dec_io.stall         = stall;
   assign dec_io.branch_en     = taken && dec_io.id_en && !stall;
   assign dec_io.branch_target = dec_io.npc_in + imm_dec;

endmodule

// File: tb/tb_instdecode.sv
// Directed self-checking bench for instdecode: decode, branches, load-use stall, writeback, reset.
module tb_instdecode;

   localparam logic [31:0] Nop  = 32'h0000_0000;
   localparam logic [31:0] Init = 32'h0000_0123;

   logic clock2;
   logic reset2;
   int   n_tests;
   int   n_fail;

   instdecode_if dec_if ();

   instdecode #(
      .NOP_WORD (Nop),
      .REG_INIT (Init)
   ) dut (
      .clock2 (clock2),
      .reset2 (reset2),
      .dec_io (dec_if.slave)
   );

   initial clock2 = 1'b0;
   always #5 clock2 = ~clock2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock2);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset2          = 1'b0;
      dec_if.id_en    = 1'b0;
      dec_if.ir_in    = Nop;
      dec_if.npc_in   = '0;
      dec_if.wb_en    = 1'b0;
      dec_if.wb_addr  = '0;
      dec_if.wb_data  = '0;
      #12;
      check("rst_a", dec_if.a_out, 32'd0);
      check("rst_irout2", dec_if.irout2, Nop);
      check("rst_rd", {27'd0, dec_if.rd_out}, 32'd0);
      check("rst_stall", {31'd0, dec_if.stall}, 32'd0);
      check("rst_branch_en", {31'd0, dec_if.branch_en}, 32'd0);
      reset2 = 1'b1;

      // Preload R1=5, R2=7, R6=0x66 and attempt a write to R0.
      dec_if.wb_en = 1'b1;
      dec_if.wb_addr = 5'd1; dec_if.wb_data = 32'd5;    tick();
      dec_if.wb_addr = 5'd2; dec_if.wb_data = 32'd7;    tick();
      dec_if.wb_addr = 5'd6; dec_if.wb_data = 32'h66;   tick();
      dec_if.wb_addr = 5'd0; dec_if.wb_data = 32'hDEAD; tick();
      dec_if.wb_en = 1'b0;

      // ADD r3,r1,r2
      dec_if.ir_in = 32'h0022_1820; dec_if.npc_in = 32'h40; dec_if.id_en = 1'b1;
      tick();
      dec_if.id_en = 1'b0;
      check("add_a", dec_if.a_out, 32'd5);
      check("add_b", dec_if.b_out, 32'd7);
      check("add_rd", {27'd0, dec_if.rd_out}, 32'd3);
      check("add_ir", dec_if.irout2, 32'h0022_1820);
      check("add_npc", dec_if.npcout2, 32'h40);
      check("add_imm", dec_if.imm_out, 32'h0000_1820);

      // Hold with id_en low
      dec_if.ir_in = 32'h0000_3820;
      tick();
      check("hold_ir", dec_if.irout2, 32'h0022_1820);
      check("hold_a", dec_if.a_out, 32'd5);

      // ADD r7,r0,r0 after the R0 write attempt
      dec_if.id_en = 1'b1; tick(); dec_if.id_en = 1'b0;
      check("r0_zero", dec_if.a_out, 32'd0);

      // Branch resolution (combinational)
      dec_if.npc_in = 32'h10; dec_if.ir_in = 32'h1000_FFFC; #1;
      check("beqz_gated", {31'd0, dec_if.branch_en}, 32'd0);
      dec_if.id_en = 1'b1; #1;
      check("beqz_r0_en", {31'd0, dec_if.branch_en}, 32'd1);
      check("beqz_target", dec_if.branch_target, 32'h0000_000C);
      dec_if.ir_in = 32'h1400_FFFC; #1;
      check("bnez_r0_en", {31'd0, dec_if.branch_en}, 32'd0);
      dec_if.ir_in = 32'h1020_FFFC; #1;
      check("beqz_r1_en", {31'd0, dec_if.branch_en}, 32'd0);
      dec_if.ir_in = 32'h1420_FFFC; #1;
      check("bnez_r1_en", {31'd0, dec_if.branch_en}, 32'd1);
      dec_if.id_en = 1'b0;

      // Load-use: LW r4,0(r1) then ADD r5,r4,r4
      dec_if.ir_in = 32'h8C24_0000; dec_if.npc_in = 32'h200; dec_if.id_en = 1'b1;
      tick();
      check("lw_rd", {27'd0, dec_if.rd_out}, 32'd4);
      dec_if.ir_in = 32'h0084_2820; dec_if.npc_in = 32'h204; #1;
      check("hz_stall", {31'd0, dec_if.stall}, 32'd1);
      tick();
      check("bub_ir", dec_if.irout2, Nop);
      check("bub_rd", {27'd0, dec_if.rd_out}, 32'd0);
      check("bub_a", dec_if.a_out, 32'd0);
      check("bub_npc", dec_if.npcout2, 32'h200);
      check("bub_stall", {31'd0, dec_if.stall}, 32'd0);
      tick();
      check("post_ir", dec_if.irout2, 32'h0084_2820);
      check("post_a", dec_if.a_out, Init);
      check("post_rd", {27'd0, dec_if.rd_out}, 32'd5);
      check("post_npc", dec_if.npcout2, 32'h204);

      // LW r4 then ADDI r?,r1,#5 whose rt field is 4: no stall
      dec_if.ir_in = 32'h8C24_0000; tick();
      dec_if.ir_in = 32'h2024_0005; #1;
      check("addi_nostall", {31'd0, dec_if.stall}, 32'd0);

      // Writeback to R6 concurrent with decode of ADD r7,r6,r0
      dec_if.ir_in = 32'h00C0_3820;
      dec_if.wb_en = 1'b1; dec_if.wb_addr = 5'd6; dec_if.wb_data = 32'hAA;
      tick();
      dec_if.wb_en = 1'b0;
`ifdef ID_WB_BYPASS_EN
      check("wb_same_cycle", dec_if.a_out, 32'hAA);
`else
      check("wb_same_cycle", dec_if.a_out, 32'h66);
`endif
      tick();
      check("wb_next_cycle", dec_if.a_out, 32'hAA);
      dec_if.id_en = 1'b0;

      // Asynchronous reset mid-stream with a pending write
      dec_if.wb_en = 1'b1; dec_if.wb_addr = 5'd1; dec_if.wb_data = 32'h99;
      reset2 = 1'b0; #1;
      check("mrst_a", dec_if.a_out, 32'd0);
      check("mrst_npc", dec_if.npcout2, 32'd0);
      check("mrst_ir", dec_if.irout2, Nop);
      check("mrst_rd", {27'd0, dec_if.rd_out}, 32'd0);
      dec_if.wb_en = 1'b0;
      #1 reset2 = 1'b1;
      dec_if.ir_in = 32'h0022_1820; dec_if.id_en = 1'b1;
      tick();
      check("mrst_r1", dec_if.a_out, Init);
      check("mrst_r2", dec_if.b_out, Init);

      // JAL with imm26 = -1
      dec_if.ir_in = 32'h0FFF_FFFF; dec_if.npc_in = 32'h100; #1;
      check("jal_br", {31'd0, dec_if.branch_en}, 32'd1);
      check("jal_target", dec_if.branch_target, 32'h0000_00FF);
      tick();
      check("jal_rd", {27'd0, dec_if.rd_out}, 32'd31);
      check("jal_imm", dec_if.imm_out, 32'hFFFF_FFFF);

      // SW r2,4(r1): no destination
      dec_if.ir_in = 32'hAC22_0004; tick();
      check("sw_rd", {27'd0, dec_if.rd_out}, 32'd0);
      check("sw_imm", dec_if.imm_out, 32'h0000_0004);
      dec_if.id_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
